// File: rtl/spi_dev_arb_rr_pkg.sv
// spi_dev_arb_rr shared definitions.
// Arbiter FSM encoding, selection policies and select-width helper.
package spi_dev_arb_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2
    } arb_state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_dev_arb_rr_pick.sv
// Rotating priority picker: first eligible channel at or above i_base.
// Double-width rotate, then lowest-bit priority encode.
module spi_dev_arb_rr_pick
    import spi_dev_arb_rr_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = sel_w(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [SW-1:0] i_base,
    output logic [N-1:0]  o_onehot,
    output logic [SW-1:0] o_idx
);

    logic [N-1:0] w_rot;
    logic         w_found;
    int           w_off;
    int           w_sum;

    always_comb begin
        w_rot   = N'({i_elig, i_elig} >> i_base);
        w_found = 1'b0;
        w_off   = 0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = i;
            end
        end
        w_sum = int'(i_base) + w_off;
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        o_idx    = SW'(w_sum);
        o_onehot = w_found ? (N'(1) << w_sum) : '0;
    end

endmodule

// File: rtl/spi_dev_arb_rr.sv
// N-way response arbiter between SPI responders and spi_dev_proto.
// Fixed or round-robin selection, mask, pw_end release, grant watchdog.
module spi_dev_arb_rr
    import spi_dev_arb_rr_pkg::*;
#(
    parameter  int N         = 4,
    parameter  int MODE      = MODE_RR,
    parameter  int TIMEOUT_W = 8,
    localparam int SW        = sel_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           us_req,
    input  logic           us_gnt,
    output logic [7:0]     us_rdata,
    output logic           us_rstb,
    input  logic [N-1:0]   ds_req,
    output logic [N-1:0]   ds_gnt,
    input  logic [8*N-1:0] ds_rdata,
    input  logic [N-1:0]   ds_rstb,
    input  logic [N-1:0]   ds_mask,
    input  logic           pw_end,
    output logic [SW-1:0]  sel,
    output logic           timeout_stb
);

    arb_state_t    r_state, w_state_nxt;
    logic [SW-1:0] r_sel, w_sel_nxt;
    logic [SW-1:0] r_ptr, w_ptr_nxt;
    logic [N-1:0]  r_oh, w_oh_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic          r_us_req, w_us_req_nxt;
    logic [7:0]    r_rdata, w_rdata_nxt;
    logic          r_rstb, w_rstb_nxt;
    logic          r_tstb, w_tstb_nxt;

    logic [N-1:0]  w_elig;
    logic [N-1:0]  w_win_oh;
    logic [SW-1:0] w_win_idx;
    logic [SW-1:0] w_base;
    logic          w_req_s;
    logic          w_msk_s;
    logic          w_stb_s;
    logic [7:0]    w_dat_s;
    logic          w_wd_exp;

    assign w_elig = ds_req & ds_mask;
    assign w_base = (MODE == MODE_RR && N > 1) ? r_ptr : '0;

    spi_dev_arb_rr_pick #(
        .N (N)
    ) u_pick (
        .i_elig   (w_elig),
        .i_base   (w_base),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx)
    );

    // One-hot owner drives all per-channel muxes
    assign w_req_s = |(ds_req & r_oh);
    assign w_msk_s = |(ds_mask & r_oh);
    assign w_stb_s = |(ds_rstb & r_oh);

    always_comb begin
        w_dat_s = '0;
        for (int i = 0; i < N; i++) begin
            if (r_oh[i]) begin
                w_dat_s = ds_rdata[8*i +: 8];
            end
        end
    end

    // Counter sits at zero outside GRANT, so entry always starts fresh
    generate
        if (TIMEOUT_W > 0) begin : g_wd
            logic [TIMEOUT_W-1:0] r_wd;

            always_ff @(posedge clk) begin
                if (rst || r_state != ST_GRANT || w_stb_s) begin
                    r_wd <= '0;
                end else if (r_wd != '1) begin
                    r_wd <= r_wd + TIMEOUT_W'(1);
                end
            end

            assign w_wd_exp = (r_state == ST_GRANT) && !w_stb_s && (&r_wd);
        end else begin : g_no_wd
            assign w_wd_exp = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_ptr_nxt    = r_ptr;
        w_oh_nxt     = r_oh;
        w_gnt_nxt    = r_gnt;
        w_us_req_nxt = r_us_req;
        w_rdata_nxt  = r_rdata;
        w_rstb_nxt   = 1'b0;
        w_tstb_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_sel_nxt    = w_win_idx;
                    w_oh_nxt     = w_win_oh;
                    w_us_req_nxt = 1'b1;
                    w_state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!w_req_s || !w_msk_s || pw_end) begin
                    w_us_req_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else if (us_gnt) begin
                    w_gnt_nxt   = r_oh;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_rdata_nxt = w_dat_s;
                w_rstb_nxt  = w_stb_s;
                if (!w_req_s || !us_gnt || pw_end || w_wd_exp) begin
                    w_gnt_nxt    = '0;
                    w_us_req_nxt = 1'b0;
                    w_tstb_nxt   = w_wd_exp;
                    w_state_nxt  = ST_IDLE;
                    if (MODE == MODE_RR) begin
                        w_ptr_nxt = (r_sel == SW'(N - 1)) ? '0
                                  : r_sel + SW'(1);
                    end
                end
            end
            default: begin
                w_gnt_nxt    = '0;
                w_us_req_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_ptr    <= '0;
            r_oh     <= '0;
            r_gnt    <= '0;
            r_us_req <= 1'b0;
            r_rdata  <= '0;
            r_rstb   <= 1'b0;
            r_tstb   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_ptr    <= w_ptr_nxt;
            r_oh     <= w_oh_nxt;
            r_gnt    <= w_gnt_nxt;
            r_us_req <= w_us_req_nxt;
            r_rdata  <= w_rdata_nxt;
            r_rstb   <= w_rstb_nxt;
            r_tstb   <= w_tstb_nxt;
        end
    end

    assign us_req      = r_us_req;
    assign ds_gnt      = r_gnt;
    assign us_rdata    = r_rdata;
    assign us_rstb     = r_rstb;
    assign sel         = r_sel;
    assign timeout_stb = r_tstb;

endmodule

// File: tb/tb_spi_dev_arb_rr.sv
// Bench for spi_dev_arb_rr: round-robin DUT (index 0) and fixed DUT (1).
// Owner/phase model checked every cycle plus literal directed checks.
module tb_spi_dev_arb_rr;

    localparam int TMAX = 15;

    typedef struct {
        int       own;
        bit       req;
        bit       gnt;
        int       ptr;
        int       wd;
        bit [7:0] rdata;
        bit       rstb;
        bit       tstb;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req   [2];
    logic [3:0]  msk   [2];
    logic [3:0]  rstb  [2];
    logic [31:0] rdata [2];
    logic        ugnt  [2];
    logic        pwe   [2];
    logic        o_req   [2];
    logic [7:0]  o_rdata [2];
    logic        o_rstb  [2];
    logic [3:0]  o_gnt   [2];
    logic [1:0]  o_sel   [2];
    logic        o_tstb  [2];
    bit          auto_g  [2];
    mdl_t        m [2];
    int          gord [$];
    int          checks = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_dev_arb_rr #(
            .N         (4),
            .MODE      (g == 0 ? 1 : 0),
            .TIMEOUT_W (4)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .us_req      (o_req[g]),
            .us_gnt      (ugnt[g]),
            .us_rdata    (o_rdata[g]),
            .us_rstb     (o_rstb[g]),
            .ds_req      (req[g]),
            .ds_gnt      (o_gnt[g]),
            .ds_rdata    (rdata[g]),
            .ds_rstb     (rstb[g]),
            .ds_mask     (msk[g]),
            .pw_end      (pwe[g]),
            .sel         (o_sel[g]),
            .timeout_stb (o_tstb[g])
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int pick(logic [3:0] e, int base);
        for (int k = 0; k < 4; k++) begin
            if (e[(base + k) % 4]) return (base + k) % 4;
        end
        return 0;
    endfunction

    function automatic mdl_t step(mdl_t s, logic [3:0] rq, logic [3:0] mk,
                                  logic [31:0] rd, logic [3:0] st,
                                  logic ug, logic pe, logic rs, int mode);
        mdl_t n;
        bit   exp_wd;
        n = s;
        n.rstb = 1'b0;
        n.tstb = 1'b0;
        if (rs) return '{default: 0};
        if (!s.req) begin
            if ((rq & mk) != 4'd0) begin
                n.own = pick(rq & mk, (mode == 1) ? s.ptr : 0);
                n.req = 1'b1;
            end
        end else if (!s.gnt) begin
            if (!rq[s.own] || !mk[s.own] || pe) begin
                n.req = 1'b0;
            end else if (ug) begin
                n.gnt = 1'b1;
                n.wd  = 0;
            end
        end else begin
            n.rstb  = st[s.own];
            n.rdata = rd[s.own*8 +: 8];
            exp_wd  = (s.wd == TMAX) && !st[s.own];
            n.wd    = st[s.own] ? 0 : ((s.wd < TMAX) ? s.wd + 1 : s.wd);
            if (!rq[s.own] || !ug || pe || exp_wd) begin
                n.req  = 1'b0;
                n.gnt  = 1'b0;
                n.tstb = exp_wd;
                n.ptr  = (s.own + 1) % 4;
            end
        end
        return n;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) m[d] = '{default: 0};
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m[d] = step(m[d], req[d], msk[d], rdata[d], rstb[d],
                        ugnt[d], pwe[d], rst, (d == 0) ? 1 : 0);
        end
    end

    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d.us_req", d), int'(o_req[d]), int'(m[d].req));
            chk($sformatf("dut%0d.ds_gnt", d), int'(o_gnt[d]),
                m[d].gnt ? (1 << m[d].own) : 0);
            chk($sformatf("dut%0d.gnt_onehot", d),
                int'($countones(o_gnt[d]) <= 1), 1);
            chk($sformatf("dut%0d.us_rstb", d), int'(o_rstb[d]), int'(m[d].rstb));
            chk($sformatf("dut%0d.timeout_stb", d), int'(o_tstb[d]),
                int'(m[d].tstb));
            if (m[d].gnt)
                chk($sformatf("dut%0d.sel", d), int'(o_sel[d]), m[d].own);
            if (m[d].rstb)
                chk($sformatf("dut%0d.us_rdata", d), int'(o_rdata[d]),
                    int'(m[d].rdata));
        end
    end

    // Upstream proto: grant follows request half a cycle later
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (auto_g[d]) ugnt[d] = o_req[d];
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_gnt(input int d, input int ch);
        int n = 0;
        while (!o_gnt[d][ch] && n < 30) begin
            tick();
            n++;
        end
        chk($sformatf("dut%0d.wait_gnt_ch%0d", d, ch), int'(o_gnt[d][ch]), 1);
    endtask

    task automatic run_resp(input int d, input logic [3:0] pat,
                            input int nb, input int ng);
        int         cnt [4];
        logic [3:0] pg;
        int         cyc;
        gord.delete();
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        pg = 4'd0;
        cyc = 0;
        req[d] = pat;
        while (gord.size() < ng && cyc < 400) begin
            tick();
            cyc++;
            rstb[d] = 4'd0;
            if (o_gnt[d] != 4'd0 && pg == 4'd0) begin
                for (int c = 0; c < 4; c++)
                    if (o_gnt[d][c]) gord.push_back(c);
            end
            for (int c = 0; c < 4; c++) begin
                if (o_gnt[d][c]) begin
                    if (cnt[c] < nb) begin
                        rstb[d][c] = 1'b1;
                        rdata[d][c*8 +: 8] = 8'(16 * c + cnt[c] + 1);
                        cnt[c]++;
                    end else begin
                        req[d][c] = 1'b0;
                        cnt[c] = 0;
                    end
                end else if (pat[c] && !req[d][c]) begin
                    req[d][c] = 1'b1;
                end
            end
            pg = o_gnt[d];
        end
        chk($sformatf("dut%0d.grant_count", d), gord.size(), ng);
        req[d] = 4'd0;
        rstb[d] = 4'd0;
        ticks(4);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int exp_rr [4];
        exp_rr = '{1, 3, 1, 3};
        for (int d = 0; d < 2; d++) begin
            req[d] = 4'd0;
            msk[d] = 4'hF;
            rstb[d] = 4'd0;
            rdata[d] = 32'd0;
            ugnt[d] = 1'b0;
            pwe[d] = 1'b0;
            auto_g[d] = 1'b1;
        end
        rst = 1'b1;
        ticks(2);
        for (int d = 0; d < 2; d++) begin
            chk("reset.us_req", int'(o_req[d]), 0);
            chk("reset.ds_gnt", int'(o_gnt[d]), 0);
            chk("reset.us_rdata", int'(o_rdata[d]), 0);
            chk("reset.us_rstb", int'(o_rstb[d]), 0);
            chk("reset.sel", int'(o_sel[d]), 0);
            chk("reset.timeout_stb", int'(o_tstb[d]), 0);
        end
        rst = 1'b0;
        ticks(2);

        // Round-robin between ch1 and ch3
        run_resp(0, 4'b1010, 3, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_order[%0d]", i),
                (i < gord.size()) ? gord[i] : -1, exp_rr[i]);

        // Fixed priority: ch1 keeps winning
        run_resp(1, 4'b1110, 1, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fixed_order[%0d]", i),
                (i < gord.size()) ? gord[i] : -1, 1);

        // Byte forwarding from ch2, ch0 strobe ignored
        req[0] = 4'b0100;
        wait_gnt(0, 2);
        rdata[0] = {8'h00, 8'hA5, 8'h00, 8'hFF};
        rstb[0] = 4'b0101;
        tick();
        chk("fwd0.us_rstb", int'(o_rstb[0]), 1);
        chk("fwd0.us_rdata", int'(o_rdata[0]), 8'hA5);
        rdata[0] = {8'h00, 8'h5A, 8'h00, 8'hFF};
        tick();
        chk("fwd1.us_rstb", int'(o_rstb[0]), 1);
        chk("fwd1.us_rdata", int'(o_rdata[0]), 8'h5A);
        rstb[0] = 4'd0;
        tick();
        chk("fwd2.us_rstb", int'(o_rstb[0]), 0);
        req[0] = 4'd0;
        ticks(4);

        // Masked request stays invisible
        msk[0] = 4'b1011;
        req[0] = 4'b0100;
        ticks(5);
        chk("mask.us_req_off", int'(o_req[0]), 0);
        msk[0] = 4'hF;
        tick();
        chk("mask.us_req_on", int'(o_req[0]), 1);
        wait_gnt(0, 2);
        req[0] = 4'd0;
        ticks(4);

        // Mask change during GRANT has no effect
        req[0] = 4'b1000;
        wait_gnt(0, 3);
        msk[0] = 4'b0111;
        ticks(3);
        chk("mask_grant.ds_gnt", int'(o_gnt[0]), 4'b1000);
        msk[0] = 4'hF;
        req[0] = 4'd0;
        ticks(4);

        // Withdrawal and pw_end abort in REQ
        auto_g[0] = 1'b0;
        ugnt[0] = 1'b0;
        req[0] = 4'b1000;
        tick();
        chk("wdraw.us_req_on", int'(o_req[0]), 1);
        msk[0] = 4'b0111;
        tick();
        chk("wdraw.us_req_off", int'(o_req[0]), 0);
        msk[0] = 4'hF;
        req[0] = 4'd0;
        ticks(3);
        req[0] = 4'b1000;
        tick();
        chk("pw_req.us_req_on", int'(o_req[0]), 1);
        pwe[0] = 1'b1;
        tick();
        chk("pw_req.us_req_off", int'(o_req[0]), 0);
        pwe[0] = 1'b0;
        req[0] = 4'd0;
        auto_g[0] = 1'b1;
        ticks(4);

        // Watchdog: silent owner released after 16 grant cycles
        req[0] = 4'b0001;
        wait_gnt(0, 0);
        n = 0;
        while (o_gnt[0][0] && n < 40) begin
            n++;
            tick();
        end
        chk("wd.grant_cycles", n, 16);
        chk("wd.timeout_stb_hi", int'(o_tstb[0]), 1);
        chk("wd.ds_gnt", int'(o_gnt[0]), 0);
        tick();
        chk("wd.timeout_stb_lo", int'(o_tstb[0]), 0);
        req[0] = 4'd0;
        ticks(4);

        // pw_end mid-GRANT
        req[0] = 4'b0010;
        wait_gnt(0, 1);
        pwe[0] = 1'b1;
        tick();
        chk("pw_grant.ds_gnt", int'(o_gnt[0]), 0);
        chk("pw_grant.us_req", int'(o_req[0]), 0);
        pwe[0] = 1'b0;
        req[0] = 4'd0;
        ticks(4);

        // Reset mid-GRANT, then arbitration resumes
        req[0] = 4'b0010;
        wait_gnt(0, 1);
        rdata[0] = 32'h0000_3C00;
        rstb[0] = 4'b0010;
        tick();
        chk("rst.pre_rdata", int'(o_rdata[0]), 8'h3C);
        rstb[0] = 4'd0;
        rst = 1'b1;
        tick();
        chk("rst.us_req", int'(o_req[0]), 0);
        chk("rst.ds_gnt", int'(o_gnt[0]), 0);
        chk("rst.us_rdata", int'(o_rdata[0]), 0);
        chk("rst.us_rstb", int'(o_rstb[0]), 0);
        chk("rst.sel", int'(o_sel[0]), 0);
        chk("rst.timeout_stb", int'(o_tstb[0]), 0);
        rst = 1'b0;
        tick();
        wait_gnt(0, 1);
        req[0] = 4'd0;
        ticks(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
